rename_free_list_mp: RTL
========================

Name: rename_free_list_mp

Overview:
Multi-lane physical-register free list for the superscalar rename stage. It is the next generation of the fixed-width free list. It adds:
- Per-lane pop requests with compaction, so partial rename groups are supported.
- Per-lane push enables with compaction, for commit and reclaim.
- C_NUM head-pointer checkpoints, giving single-cycle recovery of speculatively allocated registers.

It sits between the rename allocator (pop side), the ROB commit / walk-reclaim logic (push side) and the branch checkpoint controller.

Parameters:
P_REGISTERS, 128, number of physical registers; power of two; also the storage depth.
L_REGISTERS, 32, number of logical registers; pregs 0..L_REGISTERS-1 are architecturally mapped at reset.
POP_COUNT, 2, allocation lanes per cycle (>=1).
PUSH_COUNT, 2, release lanes per cycle (>=1).
C_NUM, 4, number of head-pointer checkpoints (>=2).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pop_req  in  POP_COUNT  per-lane allocation request; any bit pattern is legal
pop_ok  out  1  all requested lanes can be served this cycle
pop_data  out  POP_COUNT x $clog2(P_REGISTERS)  allocated preg per lane; meaningful only where pop_req=1
push_en  in  PUSH_COUNT  per-lane release enable
push_data  in  PUSH_COUNT x $clog2(P_REGISTERS)  preg being freed per lane
chk_take  in  1  capture the post-pop head into slot chk_id
chk_id  in  $clog2(C_NUM)  checkpoint slot to write
chk_restore  in  1  restore head from slot rest_id
rest_id  in  $clog2(C_NUM)  checkpoint slot to read
free_count  out  $clog2(P_REGISTERS)+1  current number of free entries
empty  out  1  free_count==0

Behaviour:
Reset (rst=1 at a clk edge):
- mem[i]=L_REGISTERS+i for i in 0..P_REGISTERS-L_REGISTERS-1.
- head=0, tail=P_REGISTERS-L_REGISTERS, free_count=P_REGISTERS-L_REGISTERS, empty=0.
- All checkpoint slots =0.
- Reset asserted mid-operation discards all in-flight state the same way; inputs are ignored that cycle.

Pointers:
- head/tail are $clog2(P_REGISTERS) bits and wrap modulo P_REGISTERS.
- Count is kept separately; no extra wrap bit.

Pop:
- n_req = popcount(pop_req).
- pop_ok = (free_count >= n_req) & ~chk_restore. pop_ok=1 when n_req=0 and no restore.
- Lane i is served from mem[head + popcount(pop_req[i-1:0])]. pop_data is combinational from current state, with zero latency.
- On pop_fire = pop_ok & (n_req != 0): head <= head + n_req.
- All-or-nothing: if pop_ok=0, nothing is popped and head is unchanged.
- Pop eligibility uses only registered free_count. Same-cycle pushes are never bypassed to pops.

Push:
- n_push = popcount(push_en).
- Lane j writes mem[tail + popcount(push_en[j-1:0])] <= push_data[j]; tail <= tail + n_push.
- Pushes are always accepted, including during chk_restore.
- A pushed entry is poppable from the next cycle.

Count (no restore):
- free_count <= free_count + n_push - (pop_fire ? n_req : 0).

Checkpoint take:
- If chk_take & ~chk_restore: ckpt[chk_id] <= head_next, i.e. head after this cycle's pop.
- chk_take is ignored when chk_restore=1.

Checkpoint restore:
- head <= ckpt[rest_id], tail <= tail + n_push.
- free_count <= (tail + n_push - ckpt[rest_id]) mod P_REGISTERS.
- If that difference is 0 and free_count+n_push was nonzero, the result is P_REGISTERS. That case cannot occur legally because free_count <= P_REGISTERS-L_REGISTERS.
- Entries between the restored head and the old head become free again. Their contents are still intact because occupancy never exceeds P_REGISTERS-L_REGISTERS.

Checkpoint slots:
- Can be re-taken at any time.
- Restoring a never-taken slot restores 0 (defined, no X).

Overflow assertion:
- free_count + n_push > P_REGISTERS-L_REGISTERS is illegal stimulus; the simulation assertion must flag it (error).

Test Plan:
1. Reset, pop_req=2'b11 for 3 cycles → pop_data pairs (32,33),(34,35),(36,37); free_count 96→94→92→90.
2. Partial group: pop_req=2'b10 → lane1 gets the head entry (e.g. 32), head+1, free_count-1. pop_req=2'b00 → pop_ok=1, no state change.
3. Drain to free_count=1, pop_req=2'b11 → pop_ok=0, head unchanged. Same cycle push_en=2'b11 (data 5,6) → free_count=3 next cycle. Then pop 2'b11 → pop_data=(last reg, 5).
4. Compacted push: push_en=2'b10 data{9,x} → 9 written at tail, tail+1. Popped in order after the existing entries.
5. chk_take slot 1 with a simultaneous 2-lane pop at head=10 → ckpt[1]=12. Pop 6 more (head=18), push 1 reg, chk_restore rest_id=1 → head=12, free_count increases by 7, pop_ok=0 that cycle.
6. Assert rst during a restore cycle → all state returns to reset values; next cycle pop_data=(32,33).

Source files
------------

// File: rtl/rename_free_list_mp.sv
// Multi-lane physical-register free list for the rename stage.
// A circular buffer of free preg numbers: rename pops from head, commit/reclaim
// pushes at tail. Pop and push lanes are compacted, and head-pointer
// checkpoints allow single-cycle recovery of speculative allocations.
module rename_free_list_mp #(
  parameter int P_REGISTERS = 128,
  parameter int L_REGISTERS = 32,
  parameter int POP_COUNT   = 2,
  parameter int PUSH_COUNT  = 2,
  parameter int C_NUM       = 4,
  localparam int PW         = $clog2(P_REGISTERS),
  localparam int IW         = $clog2(C_NUM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [POP_COUNT-1:0]               pop_req,
  output logic                               pop_ok,
  output logic [POP_COUNT-1:0][PW-1:0]       pop_data,
  input  logic [PUSH_COUNT-1:0]              push_en,
  input  logic [PUSH_COUNT-1:0][PW-1:0]      push_data,
  input  logic                               chk_take,
  input  logic [IW-1:0]                      chk_id,
  input  logic                               chk_restore,
  input  logic [IW-1:0]                      rest_id,
  output logic [PW:0]                        free_count,
  output logic                               empty
);

  localparam int CW       = PW + 1;
  localparam int FREE_MAX = P_REGISTERS - L_REGISTERS;

  // Storage and pointers
  logic [PW-1:0] mem_q  [P_REGISTERS];
  logic [PW-1:0] ckpt_q [C_NUM];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] free_count_q, free_count_d;

  // Lane compaction and next-state helpers
  logic [CW-1:0]                  n_req;
  logic [CW-1:0]                  n_push;
  logic [POP_COUNT-1:0][PW-1:0]   pop_ofs;
  logic [PUSH_COUNT-1:0][PW-1:0]  push_ofs;
  logic                           pop_fire;
  logic [PW-1:0]                  head_next;
  logic [PW-1:0]                  restore_head;
  logic [PW-1:0]                  restore_diff;

  // Prefix popcounts: each active lane's offset is the number of active lanes below it.
  always_comb begin
    // NOTE: blocking assignments are correct here; the running count must be
    // visible to the next loop iteration within the same evaluation.
    n_req = '0;
    for (int i = 0; i < POP_COUNT; i++) begin
      pop_ofs[i] = n_req[PW-1:0];
      if (pop_req[i]) n_req = n_req + CW'(1);
    end
    n_push = '0;
    for (int j = 0; j < PUSH_COUNT; j++) begin
      push_ofs[j] = n_push[PW-1:0];
      if (push_en[j]) n_push = n_push + CW'(1);
    end
  end

  // Pop side: all-or-nothing grant, zero-latency read of the compacted entries.
  always_comb begin
    pop_ok   = (free_count_q >= n_req) && !chk_restore;
    pop_fire = pop_ok && (n_req != '0);
    for (int i = 0; i < POP_COUNT; i++) begin
      pop_data[i] = mem_q[head_q + pop_ofs[i]];
    end
    head_next = pop_fire ? head_q + n_req[PW-1:0] : head_q;
  end

  // Next-state pointers and count; a restore overrides the pop path but pushes still land.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    tail_d       = tail_q + n_push[PW-1:0];
    head_d       = head_next;
    free_count_d = free_count_q + n_push - (pop_fire ? n_req : '0);
    restore_head = ckpt_q[rest_id];
    restore_diff = tail_d - restore_head;
    if (chk_restore) begin
      head_d = restore_head;
      if ((restore_diff == '0) && ((free_count_q + n_push) != '0)) begin
        free_count_d = CW'(P_REGISTERS);
      end else begin
        free_count_d = {1'b0, restore_diff};
      end
    end
  end

  // State update: pointers, count, pushed entries and checkpoint capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset on purpose; the list must come up holding
      // every non-architectural preg, so it cannot be a plain unreset RAM.
      for (int i = 0; i < P_REGISTERS; i++) begin
        mem_q[i] <= (i < FREE_MAX) ? PW'(L_REGISTERS + i) : '0;
      end
      for (int c = 0; c < C_NUM; c++) begin
        ckpt_q[c] <= '0;
      end
      head_q       <= '0;
      tail_q       <= PW'(FREE_MAX);
      free_count_q <= CW'(FREE_MAX);
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
      for (int j = 0; j < PUSH_COUNT; j++) begin
        if (push_en[j]) mem_q[tail_q + push_ofs[j]] <= push_data[j];
      end
      if (chk_take && !chk_restore) ckpt_q[chk_id] <= head_next;
    end
  end

  // Releasing more pregs than can ever be free indicates a double free upstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(free_count_q) + int'(n_push) <= FREE_MAX)
        else $error("rename_free_list_mp: free list overflow");
    end
  end

  assign free_count = free_count_q;
  assign empty      = (free_count_q == '0);

endmodule
